// File: rtl/pong_pkg.sv
// Shared definitions for the pong button-conditioning path: the per-channel
// debounce state type, button index constants and a small width helper.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;

  // Largest of three cycle counts; sizes the shared channel counters.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single pushbutton channel: 2-FF synchroniser, debounce FSM with registered
// level/press/release outputs, and step pulses. Auto-repeat on step is built
// only when BTN_AUTO_REPEAT_EN is defined; otherwise step mirrors press.
module btn_debounce_ch
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 30000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  btn_state_t      state;
  logic [CW-1:0]   cnt;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0]   rcnt;
  logic            rphase;   // 0: waiting out the initial delay, 1: periodic
`endif

  // Two-flop synchroniser for the asynchronous raw button level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM; level and pulses are registered alongside the state so that
  // level rises/falls in the same cycle as the matching pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      step_pulse    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rcnt          <= '0;
      rphase        <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      step_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= PRESS_WAIT;
            cnt   <= ONE;
          end
        end
        PRESS_WAIT: begin
          if (!sync2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= DB_LAST) begin
            // >= rather than == so DEBOUNCE_CYCLES=1 still accepts after one cycle
            state       <= HELD;
            cnt         <= '0;
            level       <= 1'b1;
            press_pulse <= 1'b1;
            step_pulse  <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            rcnt        <= '0;
            rphase      <= 1'b0;
`endif
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HELD: begin
          if (!sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= ONE;
          end else begin
`ifdef BTN_AUTO_REPEAT_EN
            if (rcnt >= (rphase ? PERIOD_LAST : DELAY_LAST)) begin
              step_pulse <= 1'b1;
              rcnt       <= '0;
              rphase     <= 1'b1;
            end else begin
              rcnt <= rcnt + ONE;
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          // repeat counter is left untouched here so a bounce back to HELD resumes it
          if (sync2) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt >= DB_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            rcnt          <= '0;
            rphase        <= 1'b0;
`endif
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the raw up/down/left/right pushbuttons for the paddle/image
// logic: one independent debounce channel per button (bit 0=U, 1=D, 2=L, 3=R).
// Define BTN_AUTO_REPEAT_EN to add auto-repeat step pulses while held.
module btn_conditioner
  import pong_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 30000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_step
);

  // One fully independent conditioning channel per button.
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk           (CLK100MHZ),
      .rst_n         (CPU_RESETN),
      .raw           (btn_raw[i]),
      .level         (btn_level[i]),
      .press_pulse   (btn_press[i]),
      .release_pulse (btn_release[i]),
      .step_pulse    (btn_step[i])
    );
  end

endmodule
